// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register and fetches from a
// variable-latency instruction memory over a req/ack handshake.
module if_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP      = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              EN,
  input  logic              stall,
  input  logic              condition_met,
  input  logic [ADDR_W-1:0] Br_Target,
  output logic              Imem_Req,
  output logic [ADDR_W-1:0] Imem_Addr,
  input  logic              Imem_Ack,
  input  logic [31:0]       Imem_Data,
  output logic [ADDR_W-1:0] Addr,
  output logic [31:0]       Id_Instr,
  output logic [ADDR_W-1:0] Id_Pc4,
  output logic              Id_Valid
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t            state, state_nxt;
  logic              hold, redir;
  logic [ADDR_W-1:0] pc_plus4, pc_nxt, drop_addr;
  logic [31:0]       hold_buf, fetch_word_p0;
  logic              fetch_vld_p0, fetch_from_buf, ifid_bubble;
  logic              buf_load, drop_load;

  // Freeze (EN=0) behaves as a stall and suppresses any redirect.
  assign hold     = stall | ~EN;
  assign redir    = condition_met & EN;
  assign pc_plus4 = Addr + ADDR_W'(4);

  assign Imem_Req  = (state == FETCH) || (state == DROP);
  assign Imem_Addr = (state == DROP) ? drop_addr : Addr;

  assign fetch_word_p0 = fetch_from_buf ? hold_buf : Imem_Data;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = Addr;
    fetch_vld_p0   = 1'b0;
    fetch_from_buf = 1'b0;
    ifid_bubble    = 1'b0;
    buf_load       = 1'b0;
    drop_load      = 1'b0;
    case (state)
      FETCH: begin
        if (Imem_Ack) begin
          if (redir) begin
            pc_nxt      = Br_Target;
            ifid_bubble = 1'b1;
          end else if (hold) begin
            // Keep the returned word so it is not refetched after the stall.
            buf_load  = 1'b1;
            state_nxt = HOLD;
          end else begin
            fetch_vld_p0 = 1'b1;
            pc_nxt       = pc_plus4;
          end
        end else if (redir) begin
          // The in-flight request cannot be cancelled; remember its address
          // so Imem_Addr stays stable until the stale ack arrives.
          drop_load   = 1'b1;
          pc_nxt      = Br_Target;
          ifid_bubble = 1'b1;
          state_nxt   = DROP;
        end else begin
          ifid_bubble = ~hold;
        end
      end
      HOLD: begin
        if (redir) begin
          pc_nxt      = Br_Target;
          ifid_bubble = 1'b1;
          state_nxt   = FETCH;
        end else if (!hold) begin
          fetch_vld_p0   = 1'b1;
          fetch_from_buf = 1'b1;
          pc_nxt         = pc_plus4;
          state_nxt      = FETCH;
        end
      end
      DROP: begin
        if (redir)    pc_nxt    = Br_Target;
        if (Imem_Ack) state_nxt = FETCH;
        ifid_bubble = redir | ~hold;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // ---- IF/ID stage boundary ----
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      Addr     <= RESET_PC;
      Id_Instr <= NOP;
      Id_Pc4   <= '0;
      Id_Valid <= 1'b0;
    end else begin
      Addr <= pc_nxt;
      if (fetch_vld_p0) begin
        Id_Instr <= fetch_word_p0;
        Id_Pc4   <= pc_plus4;
        Id_Valid <= 1'b1;
      end else if (ifid_bubble) begin
        Id_Instr <= NOP;
        Id_Valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (buf_load)  hold_buf  <= Imem_Data;
    if (drop_load) drop_addr <= Addr;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: variable-latency memory, a flag-based reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        CLR_N, EN, stall, condition_met;
  logic [31:0] Br_Target;
  logic        Imem_Req, Imem_Ack, Id_Valid;
  logic [31:0] Imem_Addr, Imem_Data, Addr, Id_Instr, Id_Pc4;

  int n_pass  = 0;
  int n_total = 0;
  int lat;
  int wcnt;

  if_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0), .NOP(NOP)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .EN(EN), .stall(stall), .condition_met(condition_met),
    .Br_Target(Br_Target), .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
    .Imem_Ack(Imem_Ack), .Imem_Data(Imem_Data), .Addr(Addr), .Id_Instr(Id_Instr),
    .Id_Pc4(Id_Pc4), .Id_Valid(Id_Valid)
  );

  always #5 CLK = ~CLK;

  // Memory: acknowledges once a request has waited lat cycles; word = addr|0xA000.
  assign Imem_Ack  = Imem_Req && (wcnt >= lat);
  assign Imem_Data = Imem_Addr | 32'hA000;

  always @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N)                    wcnt <= 0;
    else if (Imem_Req && !Imem_Ack) wcnt <= wcnt + 1;
    else                           wcnt <= 0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: tracks the PC, a buffered word and an outstanding stale fetch.
  logic [31:0] m_pc, m_instr, m_pc4, m_buf, m_drop_pc;
  logic        m_valid, m_buf_full, m_drop;
  logic        m_hold, m_redir;

  assign m_hold  = stall | ~EN;
  assign m_redir = condition_met & EN;

  always @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      m_pc <= 32'h0; m_instr <= NOP; m_pc4 <= 32'h0; m_valid <= 1'b0;
      m_buf_full <= 1'b0; m_drop <= 1'b0;
    end else if (m_buf_full) begin
      if (m_redir) begin
        m_buf_full <= 1'b0; m_pc <= Br_Target; m_instr <= NOP; m_valid <= 1'b0;
      end else if (!m_hold) begin
        m_buf_full <= 1'b0; m_pc <= m_pc + 32'd4;
        m_instr <= m_buf; m_pc4 <= m_pc + 32'd4; m_valid <= 1'b1;
      end
    end else if (m_drop) begin
      if (m_redir)  m_pc <= Br_Target;
      if (Imem_Ack) m_drop <= 1'b0;
      if (m_redir || !m_hold) begin m_instr <= NOP; m_valid <= 1'b0; end
    end else begin
      if (m_redir) begin
        m_pc <= Br_Target; m_instr <= NOP; m_valid <= 1'b0;
        if (!Imem_Ack) begin m_drop <= 1'b1; m_drop_pc <= m_pc; end
      end else if (Imem_Ack) begin
        if (m_hold) begin
          m_buf_full <= 1'b1; m_buf <= Imem_Data;
        end else begin
          m_pc <= m_pc + 32'd4; m_instr <= Imem_Data; m_pc4 <= m_pc + 32'd4; m_valid <= 1'b1;
        end
      end else if (!m_hold) begin
        m_instr <= NOP; m_valid <= 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    chk("imem_req", 32'(Imem_Req), 32'(!m_buf_full));
    chk("imem_addr", Imem_Addr, m_drop ? m_drop_pc : m_pc);
    chk("addr", Addr, m_pc);
    chk("id_instr", Id_Instr, m_instr);
    chk("id_valid", 32'(Id_Valid), 32'(m_valid));
    if (m_valid) begin
      chk("id_pc4", Id_Pc4, m_pc4);
      chk("id_word_matches_pc", Id_Instr, (m_pc4 - 32'd4) | 32'hA000);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    CLR_N = 1'b0; EN = 1'b1; stall = 1'b0; condition_met = 1'b0; Br_Target = 32'h0; lat = 0;
    step(2);
    chk("lit_rst_addr", Addr, 32'h0);
    chk("lit_rst_instr", Id_Instr, NOP);
    chk("lit_rst_pc4", Id_Pc4, 32'h0);
    chk("lit_rst_valid", 32'(Id_Valid), 32'h0);
    CLR_N = 1'b1;

    // Zero-wait streaming
    step(1);
    chk("lit_t1_addr", Addr, 32'h4);
    chk("lit_t1_instr", Id_Instr, 32'hA000);
    chk("lit_t1_pc4", Id_Pc4, 32'h4);
    chk("lit_t1_valid", 32'(Id_Valid), 32'h1);
    step(3);
    chk("lit_t1_addr10", Addr, 32'h10);
    chk("lit_t1_instr_c", Id_Instr, 32'hA00C);

    // Stall for 3 cycles at 0x10
    stall = 1'b1;
    step(3);
    chk("lit_t3_frozen_instr", Id_Instr, 32'hA00C);
    chk("lit_t3_frozen_addr", Addr, 32'h10);
    chk("lit_t3_no_req", 32'(Imem_Req), 32'h0);
    stall = 1'b0;
    step(1);
    chk("lit_t3_instr", Id_Instr, 32'hA010);
    chk("lit_t3_addr", Addr, 32'h14);

    // Redirect with ack, stall asserted alongside: redirect wins
    condition_met = 1'b1; Br_Target = 32'h40; stall = 1'b1;
    step(1);
    chk("lit_t4_addr", Addr, 32'h40);
    chk("lit_t4_valid", 32'(Id_Valid), 32'h0);
    condition_met = 1'b0; stall = 1'b0;
    step(1);
    chk("lit_t4_pc4", Id_Pc4, 32'h44);
    chk("lit_t4_instr", Id_Instr, 32'hA040);

    // Two-cycle memory: bubble / instruction alternation
    lat = 1;
    step(1);
    chk("lit_t2_bubble", 32'(Id_Valid), 32'h0);
    chk("lit_t2_wait_addr", Imem_Addr, 32'h44);
    step(1);
    chk("lit_t2_instr", Id_Instr, 32'hA044);
    step(1);
    chk("lit_t2_bubble2", Id_Instr, NOP);
    chk("lit_t2_wait_addr2", Imem_Addr, 32'h48);

    // Redirect to 0x08, then redirect away while 0x08 is still outstanding
    lat = 0; condition_met = 1'b1; Br_Target = 32'h08;
    step(1);
    lat = 3; condition_met = 1'b0;
    step(1);
    condition_met = 1'b1; Br_Target = 32'h80;
    step(1);
    condition_met = 1'b0;
    chk("lit_t5_drop_addr", Imem_Addr, 32'h08);
    chk("lit_t5_pc", Addr, 32'h80);
    step(1);
    chk("lit_t5_drop_addr2", Imem_Addr, 32'h08);
    step(1);
    chk("lit_t5_new_addr", Imem_Addr, 32'h80);
    chk("lit_t5_dropped", 32'(Id_Valid), 32'h0);
    lat = 0;
    step(1);
    chk("lit_t5_instr", Id_Instr, 32'hA080);

    // Redirect out of the buffered (stalled) state
    stall = 1'b1;
    step(1);
    condition_met = 1'b1; Br_Target = 32'h100;
    step(1);
    chk("lit_hold_redir_addr", Addr, 32'h100);
    chk("lit_hold_redir_valid", 32'(Id_Valid), 32'h0);
    condition_met = 1'b0; stall = 1'b0;
    step(1);
    chk("lit_hold_redir_instr", Id_Instr, 32'hA100);

    // EN=0 freeze; redirect ignored
    EN = 1'b0; condition_met = 1'b1; Br_Target = 32'h200;
    step(2);
    chk("lit_t6_en_addr", Addr, 32'h104);
    chk("lit_t6_en_instr", Id_Instr, 32'hA100);
    EN = 1'b1; condition_met = 1'b0;
    step(1);
    chk("lit_t6_en_release", Id_Instr, 32'hA104);
    chk("lit_t6_en_addr2", Addr, 32'h108);

    // Asynchronous reset in the middle of a memory wait
    lat = 3;
    step(1);
    #2 CLR_N = 1'b0;
    #1;
    chk("lit_t6_async_addr", Addr, 32'h0);
    chk("lit_t6_async_valid", 32'(Id_Valid), 32'h0);
    chk("lit_t6_async_instr", Id_Instr, NOP);
    chk("lit_t6_async_pc4", Id_Pc4, 32'h0);
    step(1);
    CLR_N = 1'b1; lat = 0;

    // PC wrap and unaligned target
    condition_met = 1'b1; Br_Target = 32'hFFFF_FFFC;
    step(1);
    chk("lit_wrap_addr", Addr, 32'hFFFF_FFFC);
    condition_met = 1'b0;
    step(1);
    chk("lit_wrap_pc4", Id_Pc4, 32'h0);
    chk("lit_wrap_addr0", Addr, 32'h0);
    chk("lit_wrap_instr", Id_Instr, 32'hFFFF_FFFC);
    condition_met = 1'b1; Br_Target = 32'h203;
    step(1);
    condition_met = 1'b0;
    step(1);
    chk("lit_unaligned_addr", Addr, 32'h207);
    chk("lit_unaligned_instr", Id_Instr, 32'hA203);
    step(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
